// File: rtl/radix5_input_loader.sv
// Serial-to-parallel loader: groups five accepted complex samples into one frame (points a..e)
// for the first radix-5 butterfly. Define RADIX5_DOUBLE_BUF_EN for separate collect/output banks.
module radix5_input_loader #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sop,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_img,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] a_re,
    output logic [DW-1:0] a_img,
    output logic [DW-1:0] b_re,
    output logic [DW-1:0] b_img,
    output logic [DW-1:0] c_re,
    output logic [DW-1:0] c_img,
    output logic [DW-1:0] d_re,
    output logic [DW-1:0] d_img,
    output logic [DW-1:0] e_re,
    output logic [DW-1:0] e_img,
    output logic          frame_err
);
    localparam logic [2:0] LAST_IDX = 3'd4;

    logic [2:0]    idx_q, idx_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [DW-1:0] col_re_q [5];
    logic [DW-1:0] col_im_q [5];
    logic          accept, restart, frame_done;
    logic [2:0]    slot;

    assign accept     = in_valid && in_ready_q;
    assign restart    = accept && in_sop;
    assign frame_done = accept && !in_sop && (idx_q == LAST_IDX);
    assign slot       = in_sop ? 3'd0 : idx_q;

    always_comb begin
        // NOTE: default assignment first so every path drives idx_d and no latch is inferred.
        idx_d = idx_q;
        if (restart) begin
            idx_d = 3'd1;
        end else if (accept) begin
            idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // A restart with a partially filled frame discards it and latches the error.
    assign frame_err_d = frame_err_q || (restart && (idx_q != 3'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this bank is reset on purpose; it may drive a..e, which must read zero after reset.
            for (int i = 0; i < 5; i++) begin
                col_re_q[i] <= '0;
                col_im_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < 5; i++) begin
                if (slot == 3'(i)) begin
                    col_re_q[i] <= in_re;
                    col_im_q[i] <= in_img;
                end
            end
        end
    end

`ifdef RADIX5_DOUBLE_BUF_EN
    typedef enum logic {COLLECT, PEND} state_e;

    state_e        state_q, state_d;
    logic          out_free, load_direct, load_pend;
    logic [DW-1:0] out_re_q [5];
    logic [DW-1:0] out_im_q [5];

    assign out_free = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (frame_done && !out_free) state_d = PEND;
            PEND:    if (out_valid_q && out_ready) state_d = COLLECT;
        endcase
    end

    always_comb begin
        load_direct = (state_q == COLLECT) && frame_done && out_free;
        load_pend   = (state_q == PEND) && out_valid_q && out_ready;
        in_ready_d  = (state_d == COLLECT);
        out_valid_d = load_direct || load_pend || (out_valid_q && !out_ready);
    end

    // A direct load takes point e straight from the input, since its slot is written this same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                out_re_q[i] <= '0;
                out_im_q[i] <= '0;
            end
        end else if (load_direct) begin
            for (int i = 0; i < 4; i++) begin
                out_re_q[i] <= col_re_q[i];
                out_im_q[i] <= col_im_q[i];
            end
            out_re_q[4] <= in_re;
            out_im_q[4] <= in_img;
        end else if (load_pend) begin
            for (int i = 0; i < 5; i++) begin
                out_re_q[i] <= col_re_q[i];
                out_im_q[i] <= col_im_q[i];
            end
        end
    end

    assign a_re  = out_re_q[0];
    assign a_img = out_im_q[0];
    assign b_re  = out_re_q[1];
    assign b_img = out_im_q[1];
    assign c_re  = out_re_q[2];
    assign c_img = out_im_q[2];
    assign d_re  = out_re_q[3];
    assign d_img = out_im_q[3];
    assign e_re  = out_re_q[4];
    assign e_img = out_im_q[4];
`else
    // The collect bank is the output; input stalls while a frame is presented.
    assign out_valid_d = frame_done || (out_valid_q && !out_ready);
    assign in_ready_d  = !out_valid_d;

    assign a_re  = col_re_q[0];
    assign a_img = col_im_q[0];
    assign b_re  = col_re_q[1];
    assign b_img = col_im_q[1];
    assign c_re  = col_re_q[2];
    assign c_img = col_im_q[2];
    assign d_re  = col_re_q[3];
    assign d_img = col_im_q[3];
    assign e_re  = col_re_q[4];
    assign e_img = col_im_q[4];
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/radix5_input_loader.md
# radix5_input_loader

Serial-to-parallel front end for the radix-5 FFT datapath. Accepts one complex sample per clock over a valid/ready handshake and groups five consecutive samples into a frame. Presents each frame in parallel as points a..e to the first radix-5 butterfly stage, which takes all five complex points in the same cycle. Sample data words are opaque; the block does no arithmetic on them.

## Interface
- DW, 32, width of each real/imaginary word.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_re/in_img carry a sample.
- in_ready  out  1  loader can take a sample this cycle.
- in_sop  in  1  the sample being offered is point a (index 0) of a new frame. Qualified by in_valid.
- in_re, in_img  in  DW  sample real/imaginary words.
- out_valid  out  1  a_*..e_* hold a complete frame.
- out_ready  in  1  the downstream stage takes the frame this cycle.
- a_re, a_img, b_re, b_img, c_re, c_img, d_re, d_img, e_re, e_img  out  DW each  frame points 0..4, registered.
- frame_err  out  1  sticky flag: a frame was aborted by in_sop.

## Operation
- A sample is accepted when in_valid && in_ready.
- Collection:
  - A 3-bit index idx (0..4) selects the collect-register slot a..e for each accepted sample.
  - idx advances on each accept and wraps 4 -> 0.
- Resynchronisation:
  - An accepted sample with in_sop=1 is always written to slot a and sets idx to 1.
  - If idx was not 0 at that point, the partial frame is discarded and frame_err is set.
  - An accepted sample with in_sop=0 at idx=0 is taken as point a; no error.
- Frame completion:
  - The accept at idx=4 completes a frame.
  - The frame is copied to the output registers when the output is free or is being consumed in the same cycle. That transfer sets out_valid.
- Output handshake:
  - out_valid stays high, and a..e stay stable, until out_valid && out_ready.
  - If no new frame transfers in that cycle, out_valid drops the next cycle.
- State machine on the collect side:
  - COLLECT: idx counting.
  - PEND: frame complete, waiting for the output registers.
  - COLLECT -> PEND on the idx=4 accept when the output is occupied and not being consumed.
  - PEND -> COLLECT when out_ready && out_valid. The pending frame transfers in that same cycle.
- frame_err is cleared only by reset.

## Timing
- Reset values: in_ready=1, out_valid=0, all a..e words=0, frame_err=0, idx=0, state COLLECT.
- Latency: the fifth accept at clock edge N gives out_valid=1 with the new frame in the cycle after edge N.
- Throughput:
  - Double-buffered build: one sample per clock sustained while out_ready=1, i.e. one frame every 5 cycles.
  - Single-buffer build: at most one frame every 6 cycles.
- in_ready is a registered output and does not depend on in_valid.
  - in_ready=0 only in PEND.
  - In PEND, an out_ready handshake raises in_ready the following cycle.
- Simultaneous events:
  - A fifth accept in the same cycle as the output handshake transfers directly, with no PEND and no bubble.
  - in_sop on the fifth-slot cycle restarts the frame and does not complete it.
- Reset mid-operation: asserting rst_n low immediately drops out_valid, clears idx and discards both buffers.

## Configuration
- RADIX5_DOUBLE_BUF_EN defined:
  - Separate collect and output registers; PEND state exists as described above.
- RADIX5_DOUBLE_BUF_EN undefined:
  - The collect registers drive a..e directly.
  - in_ready = !out_valid, so no sample is accepted while a frame is presented.
  - The handshake cycle itself does not accept; input resumes the next cycle.
  - PEND state and the output register bank are removed.

## Test plan
- Reset, then stream samples re=1..5, img=101..105 with in_sop on the first and out_ready=1 -> one cycle after the fifth accept: out_valid=1, a_re=1, e_re=5, e_img=105.
- Stream 20 back-to-back samples with out_ready=1:
  - Double-buffered: in_ready stays 1; four frames, out_valid pulses every 5 cycles.
  - Single-buffer: one idle cycle per frame.
- Hold out_ready=0 after frame 1, keep in_valid=1:
  - Double-buffered: frame 2 is collected and in_ready=0 after 10 accepts; frame 1 data stays stable.
  - Raise out_ready: frame 2 appears the next cycle.
- Send 3 samples, then a sample 0xAA with in_sop=1 plus 4 more -> frame_err=1, output a_re=0xAA, the earlier 3 samples never appear.
- Deassert in_valid for 2 cycles between samples 2 and 3 -> frame is still assembled in order with no error.
- Assert rst_n low while out_valid=1 and idx=2 -> out_valid=0 and all outputs 0 immediately; the next 5 samples form a clean frame.
